// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner with per-slot sampling and press/release debounce.
// Emits a one-cycle pressed strobe and the accepted key code (row*4 + col).
//
// state    | meaning
// ---------+--------------------------------------------------------------
// SCAN     | rotating the column drive, waiting for any low row
// DEBOUNCE | column frozen, counting matching slot-end samples of cand_row
// HELD     | key accepted, counting consecutive released samples
module keypad_scan #(
  parameter int SCAN_DIV = 4,
  parameter int DEB_CNT  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic [3:0] key_code,
  output logic       pressed,
  output logic       key_valid
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEB_CNT + 1);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;

  state_t        state, state_nxt;
  logic [3:0]    rs_meta, rs;
  logic [SW-1:0] slot;
  logic          slot_end;
  logic [1:0]    col_idx, col_idx_nxt;
  logic [1:0]    cand_row, cand_row_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          any_low;
  logic [1:0]    sel_row;
  logic [3:0]    key_code_nxt;
  logic          pressed_nxt, key_valid_nxt;

  assign slot_end = (slot == SW'(SCAN_DIV - 1));
  assign any_low  = ~&rs;
  assign col_n    = ~(4'b0001 << col_idx);

  // Lowest-index low row wins when several keys share the driven column.
  always_comb begin
    sel_row = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!rs[i]) sel_row = 2'(i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rs_meta <= 4'b1111;
      rs      <= 4'b1111;
      slot    <= '0;
    end else begin
      rs_meta <= row_n;
      rs      <= rs_meta;
      slot    <= slot_end ? '0 : slot + SW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= SCAN;
      col_idx   <= 2'd0;
      cand_row  <= 2'd0;
      cnt       <= '0;
      key_code  <= 4'd0;
      pressed   <= 1'b0;
      key_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      col_idx   <= col_idx_nxt;
      cand_row  <= cand_row_nxt;
      cnt       <= cnt_nxt;
      key_code  <= key_code_nxt;
      pressed   <= pressed_nxt;
      key_valid <= key_valid_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    col_idx_nxt  = col_idx;
    cand_row_nxt = cand_row;
    cnt_nxt      = cnt;
    case (state)
      SCAN: begin
        if (slot_end) begin
          if (any_low) begin
            cand_row_nxt = sel_row;
            cnt_nxt      = CW'(1);
            state_nxt    = DEBOUNCE;
          end else begin
            col_idx_nxt = col_idx + 2'd1;
          end
        end
      end
      DEBOUNCE: begin
        if (slot_end) begin
          if (any_low && sel_row == cand_row) begin
            if (cnt == CW'(DEB_CNT - 1)) begin
              cnt_nxt   = '0;
              state_nxt = HELD;
            end else begin
              cnt_nxt = cnt + CW'(1);
            end
          end else begin
            cnt_nxt     = '0;
            state_nxt   = SCAN;
            col_idx_nxt = col_idx + 2'd1;
          end
        end
      end
      HELD: begin
        if (slot_end) begin
          if (rs[cand_row]) begin
            if (cnt == CW'(DEB_CNT - 1)) begin
              cnt_nxt     = '0;
              state_nxt   = SCAN;
              col_idx_nxt = col_idx + 2'd1;
            end else begin
              cnt_nxt = cnt + CW'(1);
            end
          end else begin
            cnt_nxt = '0;
          end
        end
      end
      default: begin
        state_nxt = SCAN;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Only the DEBOUNCE->HELD transition strobes, so pressed can never repeat.
  always_comb begin
    pressed_nxt   = (state == DEBOUNCE) && (state_nxt == HELD);
    key_valid_nxt = (state_nxt == HELD);
    key_code_nxt  = pressed_nxt ? {cand_row, col_idx} : key_code;
  end

endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan: keypad matrix model, directed scenarios and random
// presses/glitches, with expected key codes scored by a separate pulse monitor.
module tb_keypad_scan;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] row_n;
  logic [3:0] col_n;
  logic [3:0] key_code;
  logic       pressed;
  logic       key_valid;

  logic [15:0] keys = 16'h0;
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [3:0]  exp_q[$];
  logic        prev_pressed = 1'b0;

  keypad_scan #(.SCAN_DIV(4), .DEB_CNT(4)) dut (
    .clk(clk), .rst(rst), .row_n(row_n), .col_n(col_n),
    .key_code(key_code), .pressed(pressed), .key_valid(key_valid)
  );

  always #5 clk = ~clk;

  // Matrix model: a row reads low iff a pressed key sits on a driven column.
  always_comb begin
    row_n = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst) begin
      n_tests++;
      if (!(col_n == 4'b1110 || col_n == 4'b1101 || col_n == 4'b1011 || col_n == 4'b0111)) begin
        n_fail++;
        $display("FAIL col_onehot: got %b", col_n);
      end
      if (pressed) begin
        n_tests++;
        if (prev_pressed) begin
          n_fail++;
          $display("FAIL pulse_width: pressed high two cycles at %0t", $time);
        end else if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_pulse: code %0d with nothing expected at %0t", key_code, $time);
        end else begin
          logic [3:0] e;
          e = exp_q.pop_front();
          if (key_code !== e) begin
            n_fail++;
            $display("FAIL pulse_code: got %0d expected %0d at %0t", key_code, e, $time);
          end
        end
      end
    end
    prev_pressed = pressed;
  end

  function automatic logic [15:0] key(input int r, input int c);
    return 16'(1) << (r*4 + c);
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset(input logic [15:0] k);
    keys = k;
    rst = 1'b1;
    step(3);
    rst = 1'b0;
  endtask

  task automatic wait_pulse(output int k);
    k = 0;
    while (!pressed && k < 100) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic chk_drained(input string name);
    chk(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    int k;
    logic [3:0] e;

    // Idle scan rotation from reset.
    do_reset(16'h0);
    chk("reset_outputs", {key_code, pressed, key_valid}, 6'b0);
    for (int i = 0; i < 64; i++) begin
      e = ~(4'b0001 << ((i / 4) % 4));
      chk("idle_scan", {col_n, pressed, key_valid}, {e, 2'b00});
      step(1);
    end

    // Key (2,2): detected at edge 12, pulse visible after edge 24.
    exp_q.push_back(4'd10);
    do_reset(key(2, 2));
    wait_pulse(k);
    chk("latency_22", k, 24);
    chk("code_22", key_code, 10);
    step(1);
    chk("valid_22", key_valid, 1);
    chk_drained("drain_22");

    exp_q.push_back(4'd11);
    do_reset(key(2, 3));
    wait_pulse(k);
    chk("latency_23", k, 28);
    chk("code_23", key_code, 11);
    step(1);
    chk_drained("drain_23");

    // Key (0,1) seen on two slot ends only: aborts and resumes at column 2.
    do_reset(key(0, 1));
    step(12);
    keys = 16'h0;
    step(4);
    chk("abort_col2", col_n, 4'b1011);
    step(4);
    chk("abort_col3", col_n, 4'b0111);
    chk("abort_valid", key_valid, 0);
    chk_drained("drain_abort");

    // Release with a one-slot bounce, then re-press.
    exp_q.push_back(4'd4);
    do_reset(key(1, 0));
    step(40);
    chk("held_valid", key_valid, 1);
    keys = 16'h0;
    step(8);
    keys = key(1, 0);
    step(4);
    keys = 16'h0;
    step(12);
    chk("bounce_still_valid", key_valid, 1);
    step(12);
    chk("release_valid", key_valid, 0);
    chk("release_code", key_code, 4);
    chk_drained("drain_bounce");
    exp_q.push_back(4'd4);
    keys = key(1, 0);
    step(60);
    chk("repress_valid", key_valid, 1);
    chk_drained("drain_repress");
    keys = 16'h0;
    step(40);

    // Two keys in one column, then an extra key on another column while held.
    exp_q.push_back(4'd7);
    keys = key(1, 3) | key(3, 3);
    step(60);
    chk("multi_code", key_code, 7);
    chk("multi_valid", key_valid, 1);
    keys = keys | key(0, 0);
    step(40);
    chk("rollover_code", key_code, 7);
    chk_drained("drain_multi");
    keys = 16'h0;
    step(50);
    chk("multi_release", key_valid, 0);

    // Reset mid-debounce.
    do_reset(key(2, 2));
    step(16);
    rst = 1'b1;
    #1;
    chk("rst_deb_outputs", {col_n, key_code, pressed, key_valid}, {4'b1110, 4'd0, 2'b00});
    keys = 16'h0;
    step(3);
    rst = 1'b0;
    step(1);
    chk("rst_deb_restart", col_n, 4'b1110);
    step(40);
    chk_drained("drain_rst_deb");

    // Reset while held.
    exp_q.push_back(4'd10);
    do_reset(key(2, 2));
    step(30);
    chk("pre_rst_valid", key_valid, 1);
    rst = 1'b1;
    #1;
    chk("rst_held_outputs", {col_n, key_code, pressed, key_valid}, {4'b1110, 4'd0, 2'b00});
    keys = 16'h0;
    step(3);
    rst = 1'b0;
    step(1);
    chk("rst_held_restart", col_n, 4'b1110);
    step(40);
    chk_drained("drain_rst_held");

    // Random: stable single-column presses vs short glitches.
    for (int it = 0; it < 16; it++) begin
      if ($urandom_range(0, 2) != 0) begin
        int c;
        int low;
        logic [3:0] mask;
        c = $urandom_range(0, 3);
        mask = 4'($urandom_range(1, 15));
        low = 4;
        keys = 16'h0;
        for (int r = 3; r >= 0; r--) begin
          if (mask[r]) begin
            keys = keys | key(r, c);
            low = r;
          end
        end
        e = 4'(low * 4 + c);
        exp_q.push_back(e);
        step(60);
        chk("rand_valid", key_valid, 1);
        chk("rand_code", key_code, e);
        keys = 16'h0;
        step(50);
        chk("rand_release", key_valid, 0);
        chk_drained("rand_drain");
      end else begin
        keys = key($urandom_range(0, 3), $urandom_range(0, 3));
        step($urandom_range(1, 8));
        keys = 16'h0;
        step(50);
        chk("glitch_valid", key_valid, 0);
        chk_drained("glitch_drain");
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
